// File: rtl/backend_pipe_ctrl_if.sv
// Request/response bundle between the backend pipes and the stall/flush controller.
// The pipes (master) raise per-pipe stall/clear requests; the controller (slave)
// answers with the shared stage sequencing vectors, issue gate and status.
interface backend_pipe_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [1:0]       ex_stall_req_i;
    logic [1:0]       m1_stall_req_i;
    logic [1:0]       m2_stall_req_i;
    logic [1:0]       ex_clr_req_i;
    logic [1:0]       m1_clr_req_i;
    logic [1:0]       m2_clr_req_i;
    logic [2:0]       stall_vec_o;
    logic [2:0]       clr_vec_o;
    logic             issue_allow_o;
    logic             frontend_flush_o;
    logic             busy_o;
    logic             timeout_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [CNT_W-1:0] flush_cnt_o;

    modport master (
        output ex_stall_req_i, m1_stall_req_i, m2_stall_req_i,
        output ex_clr_req_i, m1_clr_req_i, m2_clr_req_i,
        input  stall_vec_o, clr_vec_o, issue_allow_o, frontend_flush_o,
        input  busy_o, timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  ex_stall_req_i, m1_stall_req_i, m2_stall_req_i,
        input  ex_clr_req_i, m1_clr_req_i, m2_clr_req_i,
        output stall_vec_o, clr_vec_o, issue_allow_o, frontend_flush_o,
        output busy_o, timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/backend_pipe_ctrl.sv
// Stall/flush controller shared by backend pipe 0 (BPF/LSU/CSR) and pipe 1 (ALU).
// Stalls and clears act combinationally in the cycle they are requested; a clear
// that collides with a stall is parked and replayed on the first unstalled cycle.
// After every applied clear, issue is held off for REDIRECT_GAP cycles.
module backend_pipe_ctrl #(
    parameter int REDIRECT_GAP  = 2,
    parameter int STALL_TIMEOUT = 1024,
    parameter int CNT_W         = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    backend_pipe_ctrl_if.slave bus
);

    localparam int            TW          = $clog2(STALL_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(STALL_TIMEOUT);
    localparam logic [2:0]    GAP_LAST    = 3'(REDIRECT_GAP - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        STALL    = 2'd1,
        REDIRECT = 2'd2
    } state_t;

    state_t           state_q;
    logic [2:0]       gap_cnt_q;
    logic             issue_allow_q;
    logic             busy_q;

    logic             pend_vld_q;
    logic [1:0]       pend_stage_q;
    logic             pend_p0_q;

    logic [TW-1:0]    consec_q;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    logic [2:0]       stall_hit;
    logic [2:0]       clr_hit;
    logic             stall_any;
    logic             clr_any;
    logic             new_p0;
    logic             take_new;
    logic             apply;
    logic [1:0]       apply_stage;
    logic             apply_p0;
    logic [2:0]       stall_vec;
    logic [2:0]       clr_vec;
    logic             frontend_flush;

    // Oldest requesting stage as {found, stage}; M2 is oldest, EX youngest.
    function automatic logic [2:0] highest_stage(input logic [1:0] ex,
                                                 input logic [1:0] m1,
                                                 input logic [1:0] m2);
        if (|m2) return {1'b1, 2'd2};
        if (|m1) return {1'b1, 2'd1};
        if (|ex) return {1'b1, 2'd0};
        return 3'b000;
    endfunction

    // Pipe-0 request bit at a given stage.
    function automatic logic pipe0_bit(input logic [1:0] stage,
                                       input logic [1:0] ex,
                                       input logic [1:0] m1,
                                       input logic [1:0] m2);
        case (stage)
            2'd2:    return m2[0];
            2'd1:    return m1[0];
            default: return ex[0];
        endcase
    endfunction

    // A stall at stage s freezes every younger stage as well.
    function automatic logic [2:0] stall_mask(input logic [1:0] stage);
        case (stage)
            2'd2:    return 3'b111;
            2'd1:    return 3'b011;
            default: return 3'b001;
        endcase
    endfunction

    // A clear at stage c squashes all younger stages; stage c itself is squashed
    // only when the redirect comes from pipe 1 alone, since pipe 0 is older at
    // equal stage and would otherwise have to survive.
    function automatic logic [2:0] clear_mask(input logic [1:0] stage, input logic p0);
        logic [2:0] below;
        case (stage)
            2'd2:    below = 3'b011;
            2'd1:    below = 3'b001;
            default: below = 3'b000;
        endcase
        return p0 ? below : (below | (3'b001 << stage));
    endfunction

    // Watchdog run length saturates at the timeout value so it never wraps.
    function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] v);
        return (v == TIMEOUT_VAL) ? v : v + TW'(1);
    endfunction

    // Same-cycle stall/clear arbitration: stall wins, then newest-oldest clear.
    always_comb begin
        stall_hit      = highest_stage(bus.ex_stall_req_i, bus.m1_stall_req_i, bus.m2_stall_req_i);
        clr_hit        = highest_stage(bus.ex_clr_req_i, bus.m1_clr_req_i, bus.m2_clr_req_i);
        stall_any      = rst_n & stall_hit[2];
        clr_any        = rst_n & clr_hit[2];
        new_p0         = pipe0_bit(clr_hit[1:0], bus.ex_clr_req_i, bus.m1_clr_req_i, bus.m2_clr_req_i);
        take_new       = clr_any && (!pend_vld_q || (clr_hit[1:0] > pend_stage_q));
        apply          = !stall_any && (take_new || (rst_n && pend_vld_q));
        apply_stage    = take_new ? clr_hit[1:0] : pend_stage_q;
        apply_p0       = take_new ? new_p0 : pend_p0_q;
        stall_vec      = 3'b000;
        clr_vec        = 3'b000;
        frontend_flush = 1'b0;
        if (stall_any) begin
            stall_vec = stall_mask(stall_hit[1:0]);
            clr_vec   = 3'b001 << stall_hit[1:0];
        end else if (apply) begin
            clr_vec        = clear_mask(apply_stage, apply_p0);
            frontend_flush = 1'b1;
        end
    end

    // Park the oldest clear seen while stalled; drop it once it has been applied.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_vld_q <= 1'b0;
        end else if (stall_any) begin
            if (take_new) begin
                pend_vld_q   <= 1'b1;
                pend_stage_q <= clr_hit[1:0];
                pend_p0_q    <= new_p0;
            end
        end else begin
            pend_vld_q <= 1'b0;
        end
    end

    // Control FSM with registered issue gate and busy flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RUN;
            gap_cnt_q     <= 3'd0;
            issue_allow_q <= 1'b1;
            busy_q        <= 1'b0;
        end else if (apply) begin
            state_q       <= REDIRECT;
            gap_cnt_q     <= GAP_LAST;
            issue_allow_q <= 1'b0;
            busy_q        <= 1'b1;
        end else if ((state_q == REDIRECT) && (gap_cnt_q != 3'd0)) begin
            state_q       <= REDIRECT;
            gap_cnt_q     <= gap_cnt_q - 3'd1;
            issue_allow_q <= 1'b0;
            busy_q        <= 1'b1;
        end else if (stall_any) begin
            state_q       <= STALL;
            issue_allow_q <= 1'b1;
            busy_q        <= 1'b1;
        end else begin
            state_q       <= RUN;
            issue_allow_q <= 1'b1;
            busy_q        <= 1'b0;
        end
    end

    // Consecutive-stall watchdog with sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            consec_q  <= '0;
            timeout_q <= 1'b0;
        end else if (stall_any) begin
            consec_q <= sat_inc(consec_q);
            if (sat_inc(consec_q) == TIMEOUT_VAL) begin
                timeout_q <= 1'b1;
            end
        end else begin
            consec_q <= '0;
        end
    end

    // Free-running performance counters, wrapping naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(stall_any);
            flush_cnt_q <= flush_cnt_q + CNT_W'(apply);
        end
    end

    assign bus.stall_vec_o      = stall_vec;
    assign bus.clr_vec_o        = clr_vec;
    assign bus.frontend_flush_o = frontend_flush;
    assign bus.issue_allow_o    = issue_allow_q;
    assign bus.busy_o           = busy_q;
    assign bus.timeout_o        = timeout_q;
    assign bus.stall_cnt_o      = stall_cnt_q;
    assign bus.flush_cnt_o      = flush_cnt_q;

endmodule

// File: tb/tb_backend_pipe_ctrl.sv
// Bench for backend_pipe_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a stage-number reference model.
module tb_backend_pipe_ctrl;

    localparam int GAP = 2;
    localparam int TO  = 4;
    localparam int CW  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    backend_pipe_ctrl_if #(.CNT_W(CW)) bus ();

    backend_pipe_ctrl #(
        .REDIRECT_GAP (GAP),
        .STALL_TIMEOUT(TO),
        .CNT_W        (CW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;

    // reference model state
    int   m_scnt = 0, m_fcnt = 0, m_run = 0, m_redir = 0;
    int   pend_c = -1;
    bit   pend_p0 = 1'b0;
    bit   m_to = 1'b0, m_issue = 1'b1, m_busy = 1'b0;
    // per-cycle model results
    logic [2:0] e_svec, e_cvec;
    bit   e_flush, m_apply, m_stall;
    int   nxt_pc;
    bit   nxt_p0;
    // last observed combinational outputs
    logic [2:0] last_svec, last_cvec;
    logic       last_flush;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Evaluate the same-cycle outputs from the rules, using stage numbers 0..2.
    task automatic model_comb();
        logic [1:0] sreq[3];
        logic [1:0] creq[3];
        int s, c, ac;
        bit ap0;
        sreq[0] = bus.ex_stall_req_i; sreq[1] = bus.m1_stall_req_i; sreq[2] = bus.m2_stall_req_i;
        creq[0] = bus.ex_clr_req_i;   creq[1] = bus.m1_clr_req_i;   creq[2] = bus.m2_clr_req_i;
        s = -1; c = -1; ac = -1; ap0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (sreq[k] != 2'b00) s = k;
            if (creq[k] != 2'b00) c = k;
        end
        e_svec = 3'b000; e_cvec = 3'b000; e_flush = 1'b0; m_apply = 1'b0; m_stall = 1'b0;
        nxt_pc = pend_c; nxt_p0 = pend_p0;
        if (rst_n) begin
            if (s >= 0) begin
                m_stall = 1'b1;
                e_svec  = 3'((1 << (s + 1)) - 1);
                e_cvec  = 3'(1 << s);
                if (c > pend_c) begin
                    nxt_pc = c;
                    nxt_p0 = creq[c][0];
                end
            end else begin
                if (c > pend_c) begin
                    ac = c; ap0 = creq[c][0];
                end else if (pend_c >= 0) begin
                    ac = pend_c; ap0 = pend_p0;
                end
                if (ac >= 0) begin
                    m_apply = 1'b1;
                    e_flush = 1'b1;
                    e_cvec  = 3'((1 << ac) - 1);
                    if (!ap0) e_cvec[ac] = 1'b1;
                end
                nxt_pc = -1;
            end
        end
    endtask

    // Advance the model state across one rising edge.
    task automatic model_clock();
        if (!rst_n) begin
            m_scnt = 0; m_fcnt = 0; m_run = 0; m_redir = 0; m_to = 1'b0;
            pend_c = -1; pend_p0 = 1'b0; m_issue = 1'b1; m_busy = 1'b0;
        end else begin
            m_scnt  = (m_scnt + int'(m_stall)) % (1 << CW);
            m_fcnt  = (m_fcnt + int'(m_apply)) % (1 << CW);
            m_run   = m_stall ? m_run + 1 : 0;
            if (m_run >= TO) m_to = 1'b1;
            m_redir = m_apply ? GAP : ((m_redir > 0) ? m_redir - 1 : 0);
            m_issue = (m_redir == 0);
            m_busy  = (m_redir > 0) || m_stall;
            pend_c  = nxt_pc;
            pend_p0 = nxt_p0;
        end
    endtask

    // One clock cycle: drive, check same-cycle outputs, clock, check registered outputs.
    task automatic cyc(input logic [1:0] es, input logic [1:0] m1s, input logic [1:0] m2s,
                       input logic [1:0] ec, input logic [1:0] m1c, input logic [1:0] m2c);
        bus.ex_stall_req_i = es;  bus.m1_stall_req_i = m1s; bus.m2_stall_req_i = m2s;
        bus.ex_clr_req_i   = ec;  bus.m1_clr_req_i   = m1c; bus.m2_clr_req_i   = m2c;
        #3;
        model_comb();
        last_svec  = bus.stall_vec_o;
        last_cvec  = bus.clr_vec_o;
        last_flush = bus.frontend_flush_o;
        chk("stall_vec", 32'(bus.stall_vec_o), 32'(e_svec));
        chk("clr_vec", 32'(bus.clr_vec_o), 32'(e_cvec));
        chk("frontend_flush", 32'(bus.frontend_flush_o), 32'(e_flush));
        @(posedge clk);
        model_clock();
        #1;
        chk("issue_allow", 32'(bus.issue_allow_o), 32'(m_issue));
        chk("busy", 32'(bus.busy_o), 32'(m_busy));
        chk("timeout", 32'(bus.timeout_o), 32'(m_to));
        chk("stall_cnt", 32'(bus.stall_cnt_o), 32'(m_scnt));
        chk("flush_cnt", 32'(bus.flush_cnt_o), 32'(m_fcnt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
    endtask

    initial begin
        bus.ex_stall_req_i = 2'b00; bus.m1_stall_req_i = 2'b00; bus.m2_stall_req_i = 2'b00;
        bus.ex_clr_req_i   = 2'b00; bus.m1_clr_req_i   = 2'b00; bus.m2_clr_req_i   = 2'b00;
        @(posedge clk);
        #1;

        // reset with idle requests
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("rst_svec", 32'(last_svec), 32'h0);
        chk("rst_cvec", 32'(last_cvec), 32'h0);
        chk("rst_issue", 32'(bus.issue_allow_o), 32'h1);
        chk("rst_busy", 32'(bus.busy_o), 32'h0);
        chk("rst_cnt", 32'(bus.stall_cnt_o), 32'h0);

        // M2 stall held three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
            chk("m2st_svec", 32'(last_svec), 32'h7);
            chk("m2st_cvec", 32'(last_cvec), 32'h4);
            chk("m2st_busy", 32'(bus.busy_o), 32'h1);
        end
        chk("m2st_cnt", 32'(bus.stall_cnt_o), 32'd3);
        idle(1);
        chk("m2st_run", 32'(bus.busy_o), 32'h0);

        // pipe-0 EX clear: nothing older squashed, issue gap of two cycles
        cyc(2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00);
        chk("exclr_cvec", 32'(last_cvec), 32'h0);
        chk("exclr_flush", 32'(last_flush), 32'h1);
        chk("exclr_gap1", 32'(bus.issue_allow_o), 32'h0);
        chk("exclr_fcnt", 32'(bus.flush_cnt_o), 32'd1);
        idle(1);
        chk("exclr_gap2", 32'(bus.issue_allow_o), 32'h0);
        chk("exclr_noflush", 32'(last_flush), 32'h0);
        idle(1);
        chk("exclr_gapend", 32'(bus.issue_allow_o), 32'h1);

        // pipe-1-only EX clear squashes EX itself
        cyc(2'b00, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00);
        chk("p1clr_cvec", 32'(last_cvec), 32'h1);
        idle(3);
        // M2 clear from pipe 0 beats M1 clear from pipe 1
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 2'b10, 2'b01);
        chk("m2clr_cvec", 32'(last_cvec), 32'h3);
        idle(3);

        // clear colliding with stall is parked and replayed
        cyc(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
        chk("coll_cvec1", 32'(last_cvec), 32'h4);
        chk("coll_noflush1", 32'(last_flush), 32'h0);
        cyc(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00);
        chk("coll_noflush2", 32'(last_flush), 32'h0);
        cyc(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00);
        chk("coll_cvec3", 32'(last_cvec), 32'h1);
        chk("coll_flush3", 32'(last_flush), 32'h1);
        chk("coll_gap1", 32'(bus.issue_allow_o), 32'h0);
        idle(1);
        chk("coll_gap2", 32'(bus.issue_allow_o), 32'h0);
        idle(2);

        // pending overwritten by an older stage, younger one dropped
        cyc(2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00);
        cyc(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10);
        cyc(2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00);
        idle(1);
        chk("ovw_cvec", 32'(last_cvec), 32'h7);
        idle(3);

        // watchdog
        for (int i = 1; i <= 6; i++) begin
            cyc(2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00);
            if (i == 3) chk("wd_before", 32'(bus.timeout_o), 32'h0);
            if (i == 4) chk("wd_rise", 32'(bus.timeout_o), 32'h1);
        end
        idle(2);
        chk("wd_sticky", 32'(bus.timeout_o), 32'h1);

        // reset mid-operation discards the parked clear
        cyc(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(1);
        chk("mrst_noflush", 32'(last_flush), 32'h0);
        chk("mrst_issue", 32'(bus.issue_allow_o), 32'h1);
        chk("mrst_to", 32'(bus.timeout_o), 32'h0);
        chk("mrst_fcnt", 32'(bus.flush_cnt_o), 32'h0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            logic [1:0] r[6];
            for (int j = 0; j < 6; j++) begin
                r[j][0] = ($urandom_range(0, 9) == 0);
                r[j][1] = ($urandom_range(0, 9) == 0);
            end
            cyc(r[0], r[1], r[2], r[3], r[4], r[5]);
        end

        // stall counter wrap
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 260; i++) cyc(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
        chk("wrap_cnt", 32'(bus.stall_cnt_o), 32'd4);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/backend_pipe_ctrl.md
Name: backend_pipe_ctrl

Overview:
- Central stall/flush controller for the two backend pipelines: pipe 0 is the main pipe with BPF/LSU/CSR, and pipe 1 is the ALU-only pipe.
- Collects per-pipe, per-stage stall and clear requests and produces the shared stall_vec/clr_vec that sequences the EX/M1/M2/WB registers of both pipes.
- Latches clears that arrive during a stall and replays them when the stall lifts.
- Gates issue during the redirect recovery window.
- Maintains a stall watchdog and performance counters.

Parameters:
- REDIRECT_GAP, 2: cycles issue is held low after a clear is applied (1..7).
- STALL_TIMEOUT, 1024: consecutive stalled cycles before timeout_o asserts.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- ex_stall_req_i  in  2  per-pipe EX stall request; bit p = pipe p.
- m1_stall_req_i  in  2  per-pipe M1 stall request.
- m2_stall_req_i  in  2  per-pipe M2 stall request (LSU busy).
- ex_clr_req_i  in  2  per-pipe EX clear request (branch mispredict).
- m1_clr_req_i  in  2  per-pipe M1 clear request.
- m2_clr_req_i  in  2  per-pipe M2 clear request (exception/CSR redirect).
- stall_vec_o  out  3  bit0 EX, bit1 M1, bit2 M2; shared by both pipes.
- clr_vec_o  out  3  bit i = output of stage i becomes a bubble into stage i+1.
- issue_allow_o  out  1  frontend may assert issue.
- frontend_flush_o  out  1  one-cycle pulse when a clear is applied.
- busy_o  out  1  FSM not in RUN.
- timeout_o  out  1  sticky watchdog flag.
- stall_cnt_o  out  CNT_W  total stalled cycles.
- flush_cnt_o  out  CNT_W  total applied clears.

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset values: all outputs 0 except issue_allow_o=1; FSM=RUN; pending-clear register empty.

Stall combination:
- s = highest stage with any stall bit set in either pipe.
- stall_vec_o[k]=1 for all k<=s (the stall is combinational and same-cycle).
- clr_vec_o[s]=1, so the downstream stage (WB for s=2) receives a bubble.
- With no stall, stall_vec_o=0.

Clear combination:
- c = highest stage with any clear bit set in either pipe; c is the oldest redirect and wins.
- Applying a clear at stage c:
  - clr_vec_o[k]=1 for all k<c.
  - clr_vec_o[c]=1 additionally when the only pipe requesting at stage c is pipe 1 and the pipe-0 bit at c is 0. Pipe 0 is older at equal stage, so in this case the pipe-1 redirect squashes nothing older; this extra bit is not set otherwise.
  - frontend_flush_o pulses one cycle.
  - flush_cnt_o increments by 1.
  - FSM goes to REDIRECT.
- Clear requests are combinational and act in the same cycle when no stall is active.

Simultaneous stall and clear:
- Stall wins.
- The clear stage c and the per-pipe pipe-0 bit are latched into the pending register; clr_vec_o carries only the stall bubble.
- The pending clear is applied (combinational outputs as above) on the first cycle with no stall.
- A newer request with higher c overwrites the pending entry; lower or equal c is dropped.

FSM:
- RUN -> STALL when any stall bit is set.
- STALL -> RUN when stalls clear and nothing is pending.
- STALL -> REDIRECT when stalls clear and a clear is pending (applied that cycle).
- RUN -> REDIRECT on a clear.
- REDIRECT:
  - issue_allow_o=0 for exactly REDIRECT_GAP cycles, counting from the cycle the clear is applied.
  - A new clear in REDIRECT is applied and restarts the gap count.
  - A stall in REDIRECT stalls per the normal rules; the gap counter keeps counting.
  - Returns to RUN when the gap expires.
- busy_o = (state != RUN).
- issue_allow_o = 1 in RUN and STALL.

Watchdog and counters:
- The consecutive-stall counter increments on every cycle with stall_vec_o!=0 and resets to 0 on a non-stalled cycle.
- When it reaches STALL_TIMEOUT, timeout_o is set and stays set until reset.
- stall_cnt_o increments on each cycle with stall_vec_o!=0.
- Both perf counters wrap modulo 2^CNT_W.

Reset mid-operation:
- Pending clear is discarded, counters are zeroed, and issue_allow_o returns to 1 the cycle after reset deasserts.

Test Plan:
- Reset with all requests 0 -> stall_vec=000, clr_vec=000, issue_allow=1, busy=0, counters 0.
- m2_stall_req=01 held 3 cycles -> stall_vec=111 and clr_vec=100 for 3 cycles; stall_cnt=3; busy=1; then RUN.
- ex_clr_req=01 for 1 cycle (REDIRECT_GAP=2) -> clr_vec=000, frontend_flush pulse, issue_allow=0 for 2 cycles, flush_cnt=1.
- ex_clr_req=10 alone -> clr_vec=001. Separately, m2_clr_req=01 together with m1_clr_req=10 -> c=2, clr_vec=011.
- m2_stall_req=01 for 2 cycles with m1_clr_req=01 in the first cycle:
  - During the stall: clr_vec=100 and no flush.
  - Cycle 3: clr_vec=001, frontend_flush=1, and issue_allow=0 for the next 2 cycles.
- STALL_TIMEOUT=4 with m1_stall_req=01 held 6 cycles -> timeout_o rises in cycle 4 and remains 1 after the stall ends.
